// File: rtl/mb_pkg.sv
// Modbus RTU shared definitions: parity modes, tx FSM states,
// default clock/baud constants shared by the transmitter and receiver.
package mb_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_UART_BPS = 115_200;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_GAP
  } tx_state_t;

  function automatic logic par_bit(
    input logic [7:0] d,
    input int         mode
  );
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/mb_baud_cnt.sv
// Bit-period counter: counts 0..BPS_CNT-1 while run is high, held at 0 otherwise.
// Ports: clk, rst_n, run in; tick out (high on the last clock of each bit).
module mb_baud_cnt #(
  parameter int BPS_CNT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign tick = run && (r_cnt == CNT_LAST);

endmodule

// File: rtl/mb_uart_tx.sv
// Modbus RTU serial transmitter: valid/ready byte in, LSB-first UART out,
// t3.5 silence after the last byte of a frame, then a frame_done pulse.
// Ports: clk, rst_n, tx_data/tx_valid/tx_last in; tx_ready, uart_txd,
// tx_busy, frame_done out (all registered).
module mb_uart_tx
  import mb_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int UART_BPS  = DEF_UART_BPS,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 39
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_BITS - 1);

  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
    $error("mb_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("mb_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (BPS_CNT < 1 || BPS_CNT > 65536) begin : g_bad_bps
    $error("mb_uart_tx: CLK_FREQ/UART_BPS out of range");
  end
  if (GAP_BITS < 1 || GAP_BITS > 65536) begin : g_bad_gap
    $error("mb_uart_tx: GAP_BITS out of range");
  end

  tx_state_t   r_state;
  logic [7:0]  r_data;
  logic        r_last;
  logic [2:0]  r_idx;
  logic [15:0] r_gap_cnt;
  logic        r_txd;
  logic        r_tx_ready;
  logic        r_tx_busy;
  logic        r_frame_done;

  logic w_run;
  logic w_tick;
  logic w_par;

  assign w_run = (r_state != ST_IDLE);
  assign w_par = par_bit(r_data, PARITY);

  mb_baud_cnt #(
    .BPS_CNT(BPS_CNT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (w_run),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_idx        <= '0;
      r_gap_cnt    <= '0;
      r_txd        <= 1'b1;
      r_tx_ready   <= 1'b0;
      r_tx_busy    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_txd     <= 1'b1;
          r_tx_busy <= 1'b0;
          if (r_tx_ready && tx_valid) begin
            r_data     <= tx_data;
            r_last     <= tx_last;
            r_txd      <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_state    <= ST_START;
          end else begin
            r_tx_ready <= 1'b1;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_idx   <= '0;
            r_txd   <= r_data[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_idx == 3'd7) begin
              r_idx <= '0;
              if (PARITY != PAR_NONE) begin
                r_txd   <= w_par;
                r_state <= ST_PAR;
              end else begin
                r_txd   <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
              r_txd <= r_data[r_idx + 3'd1];
            end
          end
        end
        ST_PAR: begin
          if (w_tick) begin
            r_idx   <= '0;
            r_txd   <= 1'b1;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_idx == STOP_LAST) begin
              r_idx <= '0;
              if (r_last) begin
                r_gap_cnt <= '0;
                r_state   <= ST_GAP;
              end else begin
                r_tx_ready <= 1'b1;
                r_tx_busy  <= 1'b0;
                r_state    <= ST_IDLE;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        ST_GAP: begin
          r_txd <= 1'b1;
          if (w_tick) begin
            if (r_gap_cnt == GAP_LAST) begin
              r_gap_cnt    <= '0;
              r_frame_done <= 1'b1;
              r_tx_ready   <= 1'b1;
              r_tx_busy    <= 1'b0;
              r_state      <= ST_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + 16'd1;
            end
          end
        end
        default: begin
          r_txd      <= 1'b1;
          r_tx_ready <= 1'b0;
          r_tx_busy  <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready   = r_tx_ready;
  assign uart_txd   = r_txd;
  assign tx_busy    = r_tx_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_mb_uart_tx.sv
// Bench for mb_uart_tx: five instances (8N1, 8E1, 8O1, 8N2 at 434 clk/bit,
// and a fast 8O2 unit) checked against a bit-level frame model.
module tb_mb_uart_tx;

  localparam int NU = 5;
  localparam int CF[NU] = '{50_000_000, 50_000_000, 50_000_000, 50_000_000, 800};
  localparam int BR[NU] = '{115_200, 115_200, 115_200, 115_200, 100};
  localparam int PM[NU] = '{0, 2, 1, 0, 1};
  localparam int SB[NU] = '{1, 1, 1, 2, 2};
  localparam int GB[NU] = '{39, 39, 39, 39, 5};

  logic          clk = 1'b0;
  logic [NU-1:0] s_rst_n;
  logic [NU-1:0] s_valid;
  logic [NU-1:0] s_last;
  logic [NU-1:0] s_rdy;
  logic [NU-1:0] s_txd;
  logic [NU-1:0] s_busy;
  logic [NU-1:0] s_fd;
  logic [7:0]    s_data [NU];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fd_tot0  = 0;

  typedef struct {
    logic [2:0]  u;
    logic [7:0]  d;
    logic        last;
    logic [15:0] bits;
    int          len;
    int          par;
  } vec_t;

  vec_t vt [7];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (s_fd[0]) fd_tot0 <= fd_tot0 + 1;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    mb_uart_tx #(
      .CLK_FREQ (CF[g]),
      .UART_BPS (BR[g]),
      .PARITY   (PM[g]),
      .STOP_BITS(SB[g]),
      .GAP_BITS (GB[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (s_rst_n[g]),
      .tx_data   (s_data[g]),
      .tx_valid  (s_valid[g]),
      .tx_last   (s_last[g]),
      .tx_ready  (s_rdy[g]),
      .uart_txd  (s_txd[g]),
      .tx_busy   (s_busy[g]),
      .frame_done(s_fd[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Serial frame as a bit list, position 0 = start bit.
  function automatic logic [15:0] model_bits(
    input logic [7:0] d,
    input int         par,
    input int         sb
  );
    logic [15:0] b;
    int ones;
    int np;
    ones = $countones(d);
    np   = (par != 0) ? 1 : 0;
    b    = 16'(d) << 1;
    if (par == 2 && (ones % 2) == 1) b = b | (16'd1 << 9);
    if (par == 1 && (ones % 2) == 0) b = b | (16'd1 << 9);
    for (int i = 0; i < sb; i++) b = b | (16'd1 << (9 + np + i));
    return b;
  endfunction

  // Send one byte on unit u and compare every clock against the model.
  task automatic run_char(
    input  logic [2:0]  u,
    input  logic [7:0]  d,
    input  logic        last,
    input  logic        hold,
    output logic [15:0] got,
    output int          rdy_k,
    output int          hs
  );
    int bps = CF[u] / BR[u];
    int nb  = 9 + ((PM[u] != 0) ? 1 : 0) + SB[u];
    int L   = nb * bps;
    int G   = L + GB[u] * bps;
    int kend;
    logic [15:0] mb;
    int wait_n = 0;
    int err    = 0;
    int fd_k   = -1;
    int fd_n   = 0;
    logic et, er, eb, ef;
    kend  = last ? G + 1 : L;
    mb    = model_bits(d, PM[u], SB[u]);
    got   = '0;
    rdy_k = -1;
    hs    = -1;
    while (!s_rdy[u] && wait_n < 60000) begin
      @(negedge clk);
      wait_n++;
    end
    if (!s_rdy[u]) begin
      chk($sformatf("u%0d_ready_timeout", u), 0, 1);
      return;
    end
    s_data[u]  = d;
    s_last[u]  = last;
    s_valid[u] = 1'b1;
    @(posedge clk);
    #1;
    hs = cyc;
    if (!hold) begin
      s_valid[u] = 1'b0;
      s_data[u]  = 8'($urandom);
      s_last[u]  = 1'($urandom);
    end
    for (int k = 0; k <= kend; k++) begin
      @(negedge clk);
      et = (k < L) ? mb[4'(k / bps)] : 1'b1;
      er = last ? (k >= G) : (k >= L);
      eb = !er;
      ef = last && (k == G);
      if (k < L && (k % bps) == bps / 2) got[4'(k / bps)] = s_txd[u];
      if (s_rdy[u] && rdy_k < 0) rdy_k = k;
      if (s_fd[u]) begin
        fd_n++;
        if (fd_k < 0) fd_k = k;
      end
      if (s_txd[u] !== et || s_rdy[u] !== er ||
          s_busy[u] !== eb || s_fd[u] !== ef) err++;
    end
    chk($sformatf("u%0d_%02x_bits", u, d), int'(got), int'(mb));
    chk($sformatf("u%0d_%02x_len", u, d), rdy_k, last ? G : L);
    chk($sformatf("u%0d_%02x_shape_errs", u, d), err, 0);
    chk($sformatf("u%0d_%02x_fd_count", u, d), fd_n, last ? 1 : 0);
    if (last) chk($sformatf("u%0d_%02x_fd_at", u, d), fd_k, G);
  endtask

  initial begin
    logic [15:0] got;
    logic [7:0]  bb [4];
    logic [7:0]  rd;
    logic        rl;
    int          rk;
    int          hs;
    int          hs_prev;

    vt[0] = '{3'd0, 8'h55, 1'b0, 16'h02AA, 4340,  -1};
    vt[1] = '{3'd1, 8'hA5, 1'b0, 16'h054A, 4774,   0};
    vt[2] = '{3'd1, 8'h07, 1'b0, 16'h060E, 4774,   1};
    vt[3] = '{3'd2, 8'hA5, 1'b0, 16'h074A, 4774,   1};
    vt[4] = '{3'd2, 8'h07, 1'b0, 16'h040E, 4774,   0};
    vt[5] = '{3'd3, 8'hFF, 1'b0, 16'h07FE, 4774,  -1};
    vt[6] = '{3'd0, 8'h11, 1'b1, 16'h0222, 21266, -1};
    bb    = '{8'h01, 8'h03, 8'h00, 8'h10};

    s_rst_n = '0;
    s_valid = '0;
    s_last  = '0;
    for (int i = 0; i < NU; i++) s_data[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_txd", int'(s_txd), 31);
    chk("rst_ready", int'(s_rdy), 0);
    chk("rst_busy", int'(s_busy), 0);
    chk("rst_fd", int'(s_fd), 0);
    s_rst_n = '1;
    #1;
    chk("rel_ready_before_edge", int'(s_rdy), 0);
    @(negedge clk);
    chk("rel_ready_after_edge", int'(s_rdy), 31);

    // Reset in the middle of a character that would end a frame.
    s_data[0]  = 8'h00;
    s_last[0]  = 1'b1;
    s_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    s_valid[0] = 1'b0;
    s_last[0]  = 1'b0;
    repeat (2000) @(posedge clk);
    #2;
    chk("midchar_txd", int'(s_txd[0]), 0);
    chk("midchar_busy", int'(s_busy[0]), 1);
    s_rst_n[0] = 1'b0;
    #1;
    chk("arst_txd", int'(s_txd[0]), 1);
    chk("arst_ready", int'(s_rdy[0]), 0);
    chk("arst_busy", int'(s_busy[0]), 0);
    @(negedge clk);
    @(negedge clk);
    s_rst_n[0] = 1'b1;
    #1;
    chk("arel_ready_before_edge", int'(s_rdy[0]), 0);
    @(negedge clk);
    chk("arel_ready", int'(s_rdy[0]), 1);
    chk("arel_txd", int'(s_txd[0]), 1);
    chk("arel_busy", int'(s_busy[0]), 0);

    for (int i = 0; i < 7; i++) begin
      run_char(vt[i].u, vt[i].d, vt[i].last, 1'b0, got, rk, hs);
      chk($sformatf("tbl%0d_bits", i), int'(got), int'(vt[i].bits));
      chk($sformatf("tbl%0d_len", i), rk, vt[i].len);
      if (vt[i].par >= 0)
        chk($sformatf("tbl%0d_par", i), int'(got[9]), vt[i].par);
    end

    hs_prev = 0;
    for (int i = 0; i < 4; i++) begin
      run_char(3'd0, bb[i], 1'b0, (i < 3), got, rk, hs);
      chk($sformatf("b2b%0d_byte", i), int'(got[8:1]), int'(bb[i]));
      if (i > 0) chk($sformatf("b2b%0d_spacing", i), hs - hs_prev, 4341);
      hs_prev = hs;
    end

    for (int i = 0; i < 30; i++) begin
      rd = 8'($urandom);
      rl = ($urandom_range(3) == 0);
      repeat ($urandom_range(3)) @(negedge clk);
      run_char(3'd4, rd, rl, 1'b0, got, rk, hs);
      chk($sformatf("rnd%0d_byte", i), int'(got[8:1]), int'(rd));
    end

    chk("u0_frame_done_total", fd_tot0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mb_uart_tx.md
Name: mb_uart_tx

Overview:
- Modbus RTU serial transmitter; the transmit-side counterpart of the bus receiver.
- Takes bytes from the frame builder over a valid/ready handshake and serialises them LSB-first on uart_txd.
- Frame format: start, 8 data bits, optional parity, 1 or 2 stop bits.
- After the last byte of a frame, holds the line idle for the Modbus inter-frame silence (t3.5), then pulses frame_done.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate. Derived constant BPS_CNT = CLK_FREQ/UART_BPS (integer divide), in clocks per bit.
- PARITY, 0, 0 = none, 1 = odd, 2 = even. Any other value is an elaboration error.
- STOP_BITS, 1, 1 or 2. Any other value is an elaboration error.
- GAP_BITS, 39, inter-frame silence in bit times (3.5 chars x 11 bits, rounded up).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- tx_data  in  8  byte to send; sampled on handshake.
- tx_valid  in  1  tx_data valid.
- tx_last  in  1  byte is last of frame; sampled on handshake.
- tx_ready  out  1  block can accept a byte.
- uart_txd  out  1  serial line, idle high.
- tx_busy  out  1  character or gap in progress.
- frame_done  out  1  one-clock pulse at end of inter-frame gap.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - uart_txd = 1, tx_ready = 0, tx_busy = 0, frame_done = 0.
  - State = IDLE, all counters = 0.
- All outputs are registered. tx_ready rises on the first clk edge after reset release.
- States: IDLE, START, DATA, PAR, STOP, GAP.
- IDLE:
  - tx_ready = 1, uart_txd = 1.
  - Handshake completes at a clk edge where tx_valid && tx_ready.
  - On that edge: latch tx_data and tx_last; uart_txd <= 0; tx_ready <= 0; tx_busy <= 1; state <= START.
- Bit timing:
  - bit_cnt (16 bit) counts 0..BPS_CNT-1; each serial bit is held exactly BPS_CNT clocks.
  - The state/bit advances when bit_cnt == BPS_CNT-1, and bit_cnt wraps to 0.
- START -> DATA. In DATA, bit index 0..7 drives uart_txd = data[idx], LSB first.
- After bit 7: go to PAR if PARITY != 0, else STOP.
- PAR bit value:
  - even: XOR of the 8 data bits.
  - odd: inverse of that XOR.
- STOP: uart_txd = 1 for STOP_BITS x BPS_CNT clocks. At the end:
  - if latched tx_last = 0: state <= IDLE, tx_ready <= 1, tx_busy <= 0 on the same edge.
  - if latched tx_last = 1: state <= GAP.
- GAP:
  - uart_txd = 1, tx_ready = 0, tx_busy = 1.
  - Lasts GAP_BITS x BPS_CNT clocks; gap counter is 16 bit and counts whole bits using bit_cnt.
  - At the end: frame_done = 1 for one clock, state <= IDLE, tx_ready <= 1, tx_busy <= 0.
- Character length, handshake edge to tx_ready high: (1 + 8 + P + STOP_BITS) x BPS_CNT clocks, where P = 1 if PARITY != 0, else 0.
- Back-to-back bytes (tx_valid held high): one extra idle-high clock between characters. This is permitted.
- tx_data, tx_valid and tx_last are ignored while tx_ready = 0. Latched data is never overwritten mid-character.
- Reset asserted mid-character or mid-gap:
  - Immediately returns to reset values; the line goes high.
  - No frame_done pulse. The partial character is lost.

Decomposition:
- Shared package mb_pkg:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - tx state typedef;
  - default CLK_FREQ/UART_BPS constants shared with the receiver.
- One natural sub-module: mb_baud_cnt.
  - Parameter BPS_CNT; inputs clk, rst_n, run.
  - Output tick, asserted when count == BPS_CNT-1; count is held at 0 while run = 0.
  - Reused later by the receiver rework.

Test Plan (CLK_FREQ 50e6, UART_BPS 115200, so BPS_CNT = 434):
- 8N1, send 0x55 with tx_last = 0:
  - txd samples at mid-bit read 0,1,0,1,0,1,0,1,0,1;
  - tx_ready returns high 4340 clocks after the handshake; frame_done stays 0.
- PARITY = 2:
  - send 0xA5: parity bit 0;
  - send 0x07: parity bit 1;
  - with PARITY = 1, same bytes give parity 1 and 0;
  - character length 4774 clocks.
- Loopback into the bus receiver, bytes 0x01,0x03,0x00,0x10 back-to-back with tx_valid held:
  - the receiver reports the same 4 bytes in order;
  - exactly 1 idle clock between characters.
- tx_last = 1 on a single byte 0x11, 8N1:
  - frame_done pulses exactly 1 clock, (10+39) x 434 = 21266 clocks after the handshake;
  - tx_ready is low until that edge.
- Assert rst_n low at clock 2000 of a character:
  - uart_txd = 1 and tx_ready = 0 immediately;
  - after release tx_ready = 1 next edge; no frame_done pulse.
- STOP_BITS = 2, send 0xFF: line high for 2 x 434 clocks after bit 7; tx_ready high at 4774 clocks.
